dc_ipu_shr_pipeline_valid_chain: RTL and testbench



---
 rtl/dc_ipu_shr_pipeline_valid_chain.sv | 99 +++++++++
 tb/tb_dc_ipu_shr_pipeline_valid_chain.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dc_ipu_shr_pipeline_valid_chain.sv
// Valid/enable controller for a DEPTH-stage datapath pipeline with bubble collapsing and flush.
// Optional saturating stall counter: define DC_IPU_SHR_PIPE_STALL_CNT_EN.
module dc_ipu_shr_pipeline_valid_chain #(
   parameter int DEPTH       = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         nreset,
   input  logic                         clr,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DEPTH-1:0]             stage_en,
   output logic [DEPTH-1:0]             stage_valid,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef DC_IPU_SHR_PIPE_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0]       stall_cnt
`endif
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] en;
   logic [DEPTH-1:0] load_src;
   logic [OCC_W-1:0] occ_sum;

   // A stage may load when it is empty or its contents move on this cycle.
   assign en[DEPTH-1] = !valid_q[DEPTH-1] | out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH - 1; gi++) begin : g_en_chain
         assign en[gi] = !valid_q[gi] | en[gi+1];
      end
   endgenerate

   assign in_ready = en[0] & !clr;

   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign load_src[gi] = in_valid & in_ready;
         end else begin : g_rest
            assign load_src[gi] = valid_q[gi-1];
         end
         assign valid_d[gi] = clr ? 1'b0 : (en[gi] ? load_src[gi] : valid_q[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_comb begin
      occ_sum = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_sum = occ_sum + OCC_W'(valid_q[i]);
      end
   end

   assign stage_en    = en;
   assign stage_valid = valid_q;
   assign out_valid   = valid_q[DEPTH-1];
   assign occupancy   = occ_sum;

`ifdef DC_IPU_SHR_PIPE_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   // Flush wins over increment; the count sticks at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (clr) begin
         stall_cnt_d = '0;
      end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dc_ipu_shr_pipeline_valid_chain.sv
// Directed bench for the pipeline valid chain: DEPTH=4 vector table plus DEPTH=1 scoreboard run.
module tb_dc_ipu_shr_pipeline_valid_chain;

   logic       clk = 1'b0;
   logic       nreset;
   logic       clr, in_valid, out_ready;
   logic       in_ready, out_valid;
   logic [3:0] stage_en, stage_valid;
   logic [2:0] occupancy;
`ifdef DC_IPU_SHR_PIPE_STALL_CNT_EN
   logic [15:0] stall_cnt;
   logic        d1_stall_cnt;
`endif

   logic d1_clr, d1_in_valid, d1_out_ready;
   logic d1_in_ready, d1_out_valid;
   logic [0:0] d1_stage_en, d1_stage_valid, d1_occupancy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dc_ipu_shr_pipeline_valid_chain #(.DEPTH(4), .STALL_CNT_W(16)) u_dut (
      .clk(clk), .nreset(nreset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .stage_en(stage_en),
      .stage_valid(stage_valid), .occupancy(occupancy)
`ifdef DC_IPU_SHR_PIPE_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   dc_ipu_shr_pipeline_valid_chain #(.DEPTH(1), .STALL_CNT_W(1)) u_dut1 (
      .clk(clk), .nreset(nreset), .clr(d1_clr), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
      .out_valid(d1_out_valid), .out_ready(d1_out_ready), .stage_en(d1_stage_en),
      .stage_valid(d1_stage_valid), .occupancy(d1_occupancy)
`ifdef DC_IPU_SHR_PIPE_STALL_CNT_EN
      , .stall_cnt(d1_stall_cnt)
`endif
   );

   typedef struct {
      logic        clr;
      logic        iv;
      logic        ordy;
      logic [3:0]  ev;
      logic [3:0]  een;
      logic        eir;
      logic [15:0] est;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic c, input logic iv, input logic ordy, input logic [3:0] ev,
                          input logic [3:0] een, input logic eir, input logic [15:0] est);
      vec_t v;
      v.clr = c; v.iv = iv; v.ordy = ordy; v.ev = ev; v.een = een; v.eir = eir; v.est = est;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   int   acc_cnt, del_cnt, acc_model;
   logic m_v, m_en;

   initial begin
      nreset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      d1_clr = 1'b0; d1_in_valid = 1'b0; d1_out_ready = 1'b0;

      // clr iv ordy | stage_valid before edge, stage_en, in_ready, stall_cnt
      for (int i = 0; i < 4; i++) add_vec(0, 1, 1, 4'((1 << i) - 1), 4'b1111, 1, 0);
      add_vec(0, 1, 1, 4'b1111, 4'b1111, 1, 0);
      add_vec(0, 1, 1, 4'b1111, 4'b1111, 1, 0);
      for (int i = 0; i < 5; i++) add_vec(0, 1, 0, 4'b1111, 4'b0000, 0, 16'(i));
      add_vec(0, 0, 1, 4'b1111, 4'b1111, 1, 5);
      add_vec(0, 0, 1, 4'b1110, 4'b1111, 1, 5);
      add_vec(0, 0, 1, 4'b1100, 4'b1111, 1, 5);
      add_vec(0, 0, 1, 4'b1000, 4'b1111, 1, 5);
      add_vec(0, 1, 0, 4'b0000, 4'b1111, 1, 5);
      add_vec(0, 0, 0, 4'b0001, 4'b1111, 1, 5);
      add_vec(0, 1, 0, 4'b0010, 4'b1111, 1, 5);
      add_vec(0, 0, 0, 4'b0101, 4'b1111, 1, 5);
      add_vec(0, 0, 0, 4'b1010, 4'b0111, 1, 5);
      add_vec(0, 0, 0, 4'b1100, 4'b0011, 1, 6);
      add_vec(0, 1, 0, 4'b1100, 4'b0011, 1, 7);
      add_vec(0, 1, 0, 4'b1101, 4'b0011, 1, 8);
      add_vec(0, 1, 0, 4'b1111, 4'b0000, 0, 9);
      add_vec(1, 1, 1, 4'b1111, 4'b1111, 0, 10);
      add_vec(0, 0, 1, 4'b0000, 4'b1111, 1, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset stage_valid", 32'(stage_valid), 0);
      chk("reset occupancy", 32'(occupancy), 0);
      chk("reset in_ready", 32'(in_ready), 1);
      chk("reset stage_en", 32'(stage_en), 32'hf);
`ifdef DC_IPU_SHR_PIPE_STALL_CNT_EN
      chk("reset stall_cnt", 32'(stall_cnt), 0);
`endif
      @(negedge clk);
      nreset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         clr = vecs[i].clr; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("v%0d stage_valid", i), 32'(stage_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d stage_en", i), 32'(stage_en), 32'(vecs[i].een));
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev[3]));
         chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'($countones(vecs[i].ev)));
`ifdef DC_IPU_SHR_PIPE_STALL_CNT_EN
         chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].est));
`endif
      end

      // Build 4'b1010 with out_ready low, then reset between clock edges.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clr = 1'b0; out_ready = 1'b0; in_valid = (i % 2 == 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre-reset stage_valid", 32'(stage_valid), 32'hA);
      #2;
      nreset = 1'b0;
      #1;
      chk("async reset stage_valid", 32'(stage_valid), 0);
      chk("async reset out_valid", 32'(out_valid), 0);
      chk("async reset occupancy", 32'(occupancy), 0);
      chk("async reset in_ready", 32'(in_ready), 1);
      chk("async reset stage_en", 32'(stage_en), 32'hf);
      @(negedge clk);
      nreset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("resume stage_valid", 32'(stage_valid), 32'h1);
      @(negedge clk);
      in_valid = 1'b0;

      // DEPTH=1: alternating out_ready with in_valid held high, checked against a one-flag model.
      acc_cnt = 0; del_cnt = 0; acc_model = 0; m_v = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i < 20) begin
            d1_in_valid = 1'b1; d1_out_ready = (i % 2 == 0);
         end else begin
            d1_in_valid = 1'b0; d1_out_ready = 1'b1;
         end
         #1;
         m_en = !m_v | d1_out_ready;
         chk($sformatf("d1 c%0d out_valid", i), 32'(d1_out_valid), 32'(m_v));
         chk($sformatf("d1 c%0d in_ready", i), 32'(d1_in_ready), 32'(m_en));
         if (d1_in_valid && d1_in_ready) acc_cnt++;
         if (d1_out_valid && d1_out_ready) del_cnt++;
         if (d1_in_valid && m_en) acc_model++;
         if (m_en) m_v = d1_in_valid;
      end
      chk("d1 accepted==delivered", 32'(acc_cnt), 32'(del_cnt));
      chk("d1 accepted count", 32'(acc_cnt), 32'(acc_model));
      chk("d1 drained", 32'(d1_out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
